matrix_out_fifo: RTL

MATRIX_OUT_FIFO -- requirements
Module: matrix_out_fifo

---
 rtl/matrix_out_fifo_if.sv | 33 +++
 rtl/matrix_out_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/matrix_out_fifo_if.sv
// Handshake/bus bundle for matrix_out_fifo: producer push port, FWFT consumer port,
// element select and status. master = producer/consumer side, slave = FIFO side.
interface matrix_out_fifo_if #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned MAT_W = ELEM_W * DIM * DIM;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SEL_W = (DIM > 1) ? $clog2(DIM) : 1;

  logic             write_data;
  logic [MAT_W-1:0] data_to_write;
  logic             full;
  logic             data_valid;
  logic             data_ready;
  logic [MAT_W-1:0] data;
  logic [SEL_W-1:0] elem_row;
  logic [SEL_W-1:0] elem_col;
  logic [ELEM_W-1:0] elem_data;
  logic [CNT_W-1:0] count;
  logic [1:0]       err;

  modport master (
    output write_data, data_to_write, data_ready, elem_row, elem_col,
    input  full, data_valid, data, elem_data, count, err
  );

  modport slave (
    input  write_data, data_to_write, data_ready, elem_row, elem_col,
    output full, data_valid, data, elem_data, count, err
  );
endinterface

// File: rtl/matrix_out_fifo.sv
// First-word-fall-through FIFO of DIM x DIM matrices with a combinational element tap.
// Optional sticky error flags {underflow, overflow} under macro MATRIX_OUT_FIFO_ERR_EN.
module matrix_out_fifo #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  matrix_out_fifo_if.slave bus
);
  localparam int unsigned MAT_W = ELEM_W * DIM * DIM;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic             full_q, valid_q;
  logic [MAT_W-1:0] data_q, data_next;
  logic             push_c, pop_c;
  int unsigned      elem_sel;

  assign pop_c  = valid_q & bus.data_ready;
  assign push_c = bus.write_data & (~full_q | pop_c);

  // Next count and next head; head is a register so it reads zero after reset
  always_comb begin
    count_next = count_q;
    data_next  = data_q;
    case ({push_c, pop_c})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
    if (push_c && (count_q == CNT_W'(0) || (pop_c && count_q == CNT_W'(1))))
      data_next = bus.data_to_write;
    else if (pop_c && count_q > CNT_W'(1))
      data_next = mem[rd_ptr_q + PTR_W'(1)];
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr_q] <= bus.data_to_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_next;
      full_q  <= (count_next == CNT_W'(DEPTH));
      valid_q <= (count_next != CNT_W'(0));
      data_q  <= data_next;
    end
  end

`ifdef MATRIX_OUT_FIFO_ERR_EN
  logic [1:0] err_q;

  // err[0]: push dropped while full; err[1]: pop requested while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      if (bus.write_data && full_q && !pop_c) err_q[0] <= 1'b1;
      if (bus.data_ready && !valid_q)         err_q[1] <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 2'b00;
`endif

  always_comb begin
    elem_sel = (32'(bus.elem_row) * DIM + 32'(bus.elem_col)) * ELEM_W;
  end

  assign bus.elem_data  = ELEM_W'(data_q >> elem_sel);
  assign bus.data       = data_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.data_valid = valid_q;
endmodule
